// File: rtl/hpm_counter_bank.sv
// Bank of 64-bit hardware performance counters (mcycle, minstret, mhpmcounterN)
// with inhibit, split-half XLEN=32 writes, sticky overflow flags and a registered read port.
module hpm_counter_bank #(
  parameter int          XLEN     = 64,
  parameter int          NUM_CTRS = 32,
  parameter logic [31:0] CTR_MASK = 32'hFFFF_FFFF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_CTRS-1:0] CountEvent,
  input  logic [NUM_CTRS-1:0] Inhibit,
  input  logic                CSRWrEn,
  input  logic [4:0]          CSRWrAdr,
  input  logic                CSRWrHi,
  input  logic [XLEN-1:0]     CSRWrData,
  input  logic                CSRRdEn,
  input  logic [4:0]          CSRRdAdr,
  input  logic                CSRRdHi,
  output logic [XLEN-1:0]     CSRRdData,
  output logic [NUM_CTRS-1:0] OvfSticky,
  input  logic [NUM_CTRS-1:0] OvfClr
);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("hpm_counter_bank: XLEN must be 32 or 64");
    end
    if (NUM_CTRS < 3 || NUM_CTRS > 32) begin : g_bad_num_ctrs
      $error("hpm_counter_bank: NUM_CTRS must be in 3..32");
    end
  endgenerate

  // Slot 1 is the time CSR, which lives in the CLINT, so it is never implemented here.
  localparam logic [NUM_CTRS-1:0] ACTIVE = CTR_MASK[NUM_CTRS-1:0] & ~(NUM_CTRS'(2));

  logic [63:0]     ctr [NUM_CTRS];
  logic [31:0]     wr_lo;
  logic [31:0]     wr_hi;
  logic            wr_lo_en;
  logic            wr_hi_en;
  logic [63:0]     rd_sel;
  logic [XLEN-1:0] rd_fmt;

  generate
    if (XLEN == 64) begin : g_xlen64
      logic unused_hi_sel;
      assign unused_hi_sel = CSRWrHi ^ CSRRdHi;
      assign wr_lo    = CSRWrData[31:0];
      assign wr_hi    = CSRWrData[63:32];
      assign wr_lo_en = 1'b1;
      assign wr_hi_en = 1'b1;
      assign rd_fmt   = rd_sel;
    end else begin : g_xlen32
      // One 32-bit write replaces one half; the other half of the counter is kept.
      assign wr_lo    = CSRWrData;
      assign wr_hi    = CSRWrData;
      assign wr_lo_en = ~CSRWrHi;
      assign wr_hi_en = CSRWrHi;
      assign rd_fmt   = CSRRdHi ? rd_sel[63:32] : rd_sel[31:0];
    end
  endgenerate

  // NOTE: always_comb gives rd_sel a default before the loop so no latch is inferred
  // when the address matches no slot (out-of-range index reads as 0).
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_CTRS; i++) begin
      if (CSRRdAdr == 5'(i)) rd_sel = ctr[i];
    end
  end

  // NOTE: every counter is a flop reset asynchronously to 0; the array is register
  // state, not a RAM macro, so it is cleared in the reset branch like any other flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CTRS; i++) ctr[i] <= '0;
      OvfSticky <= '0;
    end else begin
      for (int i = 0; i < NUM_CTRS; i++) begin
        if (!ACTIVE[i]) begin
          ctr[i]       <= '0;
          OvfSticky[i] <= 1'b0;
        end else if (CSRWrEn && CSRWrAdr == 5'(i)) begin
          // A write suppresses that cycle's increment and can never raise overflow.
          ctr[i] <= {wr_hi_en ? wr_hi : ctr[i][63:32],
                     wr_lo_en ? wr_lo : ctr[i][31:0]};
          if (OvfClr[i]) OvfSticky[i] <= 1'b0;
        end else begin
          if (CountEvent[i] && !Inhibit[i]) ctr[i] <= ctr[i] + 64'd1;
          if (CountEvent[i] && !Inhibit[i] && (&ctr[i])) OvfSticky[i] <= 1'b1;
          else if (OvfClr[i])                             OvfSticky[i] <= 1'b0;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value; the read therefore returns the counter before this cycle's update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     CSRRdData <= '0;
    else if (CSRRdEn) CSRRdData <= rd_fmt;
  end

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Self-checking bench: three configurations (XLEN=64, XLEN=32, masked 8-slot) driven
// in lock-step and compared against a behavioural counter model.
module tb_hpm_counter_bank;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] ev, inh, clr;
  logic        wr_en, wr_hi, rd_en, rd_hi;
  logic [4:0]  wr_adr, rd_adr;
  logic [63:0] wr_data;

  logic [63:0] rd64, rdm;
  logic [31:0] rd32;
  logic [31:0] ovf64, ovf32;
  logic [7:0]  ovfm;

  int checks = 0;
  int errors = 0;

  // Model state per configuration: 0 = XLEN64/32 slots, 1 = XLEN32/32 slots, 2 = XLEN64/8 slots mask 7
  logic [63:0] mc [3][32];
  logic [31:0] mo [3];
  logic [63:0] exp_rd [3];

  hpm_counter_bank #(.XLEN(64), .NUM_CTRS(32), .CTR_MASK(32'hFFFF_FFFF)) u_dut64 (
    .clk(clk), .reset_n(reset_n), .CountEvent(ev), .Inhibit(inh),
    .CSRWrEn(wr_en), .CSRWrAdr(wr_adr), .CSRWrHi(wr_hi), .CSRWrData(wr_data),
    .CSRRdEn(rd_en), .CSRRdAdr(rd_adr), .CSRRdHi(rd_hi), .CSRRdData(rd64),
    .OvfSticky(ovf64), .OvfClr(clr));

  hpm_counter_bank #(.XLEN(32), .NUM_CTRS(32), .CTR_MASK(32'hFFFF_FFFF)) u_dut32 (
    .clk(clk), .reset_n(reset_n), .CountEvent(ev), .Inhibit(inh),
    .CSRWrEn(wr_en), .CSRWrAdr(wr_adr), .CSRWrHi(wr_hi), .CSRWrData(wr_data[31:0]),
    .CSRRdEn(rd_en), .CSRRdAdr(rd_adr), .CSRRdHi(rd_hi), .CSRRdData(rd32),
    .OvfSticky(ovf32), .OvfClr(clr));

  hpm_counter_bank #(.XLEN(64), .NUM_CTRS(8), .CTR_MASK(32'h0000_0007)) u_dutm (
    .clk(clk), .reset_n(reset_n), .CountEvent(ev[7:0]), .Inhibit(inh[7:0]),
    .CSRWrEn(wr_en), .CSRWrAdr(wr_adr), .CSRWrHi(wr_hi), .CSRWrData(wr_data),
    .CSRRdEn(rd_en), .CSRRdAdr(rd_adr), .CSRRdHi(rd_hi), .CSRRdData(rdm),
    .OvfSticky(ovfm), .OvfClr(clr[7:0]));

  always #5 clk = ~clk;

  function automatic bit is_active(int c, int i);
    int          n;
    logic [31:0] mask;
    n    = (c == 2) ? 8 : 32;
    mask = (c == 2) ? 32'h0000_0007 : 32'hFFFF_FFFF;
    return (i < n) && mask[i] && (i != 1);
  endfunction

  function automatic logic [63:0] read_fmt(int c, logic [63:0] v);
    if (c == 1) return rd_hi ? {32'b0, v[63:32]} : {32'b0, v[31:0]};
    return v;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 32; i++) mc[c][i] = '0;
      mo[c]     = '0;
      exp_rd[c] = '0;
    end
  endtask

  task automatic idle();
    ev = '0; inh = '0; clr = '0;
    wr_en = 1'b0; wr_hi = 1'b0; wr_adr = '0; wr_data = '0;
    rd_en = 1'b0; rd_hi = 1'b0; rd_adr = '0;
  endtask

  // Advance the model by one clock using the inputs currently applied, then clock the DUTs.
  task automatic tick();
    logic [64:0] sum;
    bit          set;
    for (int c = 0; c < 3; c++) begin
      if (rd_en) exp_rd[c] = read_fmt(c, mc[c][rd_adr]);
      for (int i = 0; i < 32; i++) begin
        if (is_active(c, i)) begin
          set = 1'b0;
          if (wr_en && wr_adr == 5'(i)) begin
            if (c != 1)     mc[c][i]        = wr_data;
            else if (wr_hi) mc[c][i][63:32] = wr_data[31:0];
            else            mc[c][i][31:0]  = wr_data[31:0];
          end else if (ev[i] && !inh[i]) begin
            sum      = {1'b0, mc[c][i]} + 65'd1;
            mc[c][i] = sum[63:0];
            set      = sum[64];
          end
          if (set)         mo[c][i] = 1'b1;
          else if (clr[i]) mo[c][i] = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [4:0] adr, input logic hi);
    rd_en = 1'b1; rd_adr = adr; rd_hi = hi;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] adr, input logic hi, input logic [63:0] data);
    wr_en = 1'b1; wr_adr = adr; wr_hi = hi; wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({rd64, rd32, rdm} !== '0) begin
      errors++; $display("FAIL reset_rd: got %h/%h/%h expected 0", rd64, rd32, rdm);
    end
    checks++;
    if ({ovf64, ovf32, ovfm} !== '0) begin
      errors++; $display("FAIL reset_ovf: got %h/%h/%h expected 0", ovf64, ovf32, ovfm);
    end
    rd_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rd64 !== 64'd0) begin
      errors++; $display("FAIL reset_hold_rd: got %h expected 0", rd64);
    end
    rd_en = 1'b0;
    reset_n = 1'b1;
    model_clear();
  endtask

  task automatic test_count();
    ev[0] = 1'b1;
    repeat (10) tick();
    ev[0] = 1'b0;
    do_read(5'd0, 1'b0);
    checks++;
    if (rd64 !== 64'd10) begin errors++; $display("FAIL count_rd64: got %0d expected 10", rd64); end
    checks++;
    if (rd32 !== 32'd10) begin errors++; $display("FAIL count_rd32: got %0d expected 10", rd32); end
    checks++;
    if (rdm !== 64'd10) begin errors++; $display("FAIL count_rdm: got %0d expected 10", rdm); end
    ev[0] = 1'b1;
    tick();
    ev[0] = 1'b0;
    checks++;
    if (rd64 !== 64'd10) begin errors++; $display("FAIL count_hold: got %0d expected 10", rd64); end
  endtask

  task automatic test_inhibit();
    ev[2] = 1'b1; inh[2] = 1'b1;
    repeat (5) tick();
    inh[2] = 1'b0;
    repeat (3) tick();
    ev[2] = 1'b0;
    do_read(5'd2, 1'b0);
    checks++;
    if (rd64 !== 64'd3) begin errors++; $display("FAIL inhibit_rd64: got %0d expected 3", rd64); end
    checks++;
    if (rdm !== 64'd3) begin errors++; $display("FAIL inhibit_rdm: got %0d expected 3", rdm); end
    ev[1] = 1'b1;
    repeat (4) tick();
    do_read(5'd1, 1'b0);
    ev[1] = 1'b0;
    checks++;
    if ({rd64, rd32, rdm} !== '0) begin
      errors++; $display("FAIL time_slot_rd: got %h/%h/%h expected 0", rd64, rd32, rdm);
    end
  endtask

  task automatic test_overflow();
    do_write(5'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    do_write(5'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE);
    ev[3] = 1'b1;
    tick();
    checks++;
    if (ovf64[3] !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", ovf64[3]); end
    tick();
    ev[3] = 1'b0;
    checks++;
    if (ovf64[3] !== 1'b1) begin errors++; $display("FAIL ovf64_set: got %b expected 1", ovf64[3]); end
    checks++;
    if (ovf32[3] !== 1'b1) begin errors++; $display("FAIL ovf32_set: got %b expected 1", ovf32[3]); end
    checks++;
    if (ovfm !== 8'h00) begin errors++; $display("FAIL ovfm_inactive: got %h expected 00", ovfm); end
    do_read(5'd3, 1'b0);
    checks++;
    if (rd64 !== 64'd0) begin errors++; $display("FAIL ovf_wrap_rd: got %h expected 0", rd64); end
    do_write(5'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    do_write(5'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    ev[3] = 1'b1; clr[3] = 1'b1;
    tick();
    ev[3] = 1'b0;
    checks++;
    if (ovf64[3] !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b expected 1", ovf64[3]); end
    tick();
    clr[3] = 1'b0;
    checks++;
    if (ovf64[3] !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", ovf64[3]); end
    do_write(5'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    checks++;
    if (ovf64[3] !== 1'b0) begin errors++; $display("FAIL ovf_write_nosets: got %b expected 0", ovf64[3]); end
  endtask

  task automatic test_write_vs_inc();
    ev[4] = 1'b1;
    repeat (3) tick();
    wr_en = 1'b1; wr_adr = 5'd4; wr_hi = 1'b0; wr_data = 64'd100;
    rd_en = 1'b1; rd_adr = 5'd4; rd_hi = 1'b0;
    tick();
    wr_en = 1'b0; rd_en = 1'b0; ev[4] = 1'b0;
    checks++;
    if (rd64 !== 64'd3) begin errors++; $display("FAIL wvi_prior: got %0d expected 3", rd64); end
    checks++;
    if (rdm !== 64'd0) begin errors++; $display("FAIL wvi_inactive: got %0d expected 0", rdm); end
    do_read(5'd4, 1'b0);
    checks++;
    if (rd64 !== 64'd100) begin errors++; $display("FAIL wvi_rd64: got %0d expected 100", rd64); end
    checks++;
    if (rd32 !== 32'd100) begin errors++; $display("FAIL wvi_rd32: got %0d expected 100", rd32); end
  endtask

  task automatic test_split32();
    do_write(5'd5, 1'b1, 64'd1);
    do_write(5'd5, 1'b0, 64'hFFFF_FFFF);
    do_write(5'd5, 1'b1, 64'hA);
    do_read(5'd5, 1'b1);
    checks++;
    if (rd32 !== 32'hA) begin errors++; $display("FAIL split_hi1: got %h expected 0000000a", rd32); end
    do_read(5'd5, 1'b0);
    checks++;
    if (rd32 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL split_lo1: got %h expected ffffffff", rd32); end
    do_write(5'd5, 1'b0, 64'd0);
    do_read(5'd5, 1'b1);
    checks++;
    if (rd32 !== 32'hA) begin errors++; $display("FAIL split_hi2: got %h expected 0000000a", rd32); end
    do_read(5'd5, 1'b0);
    checks++;
    if (rd32 !== 32'h0) begin errors++; $display("FAIL split_lo2: got %h expected 0", rd32); end
    checks++;
    if (rd64 !== exp_rd[0]) begin errors++; $display("FAIL split_rd64: got %h expected %h", rd64, exp_rd[0]); end
  endtask

  task automatic test_mask();
    do_write(5'd6, 1'b0, 64'h1234);
    do_read(5'd6, 1'b0);
    checks++;
    if (rdm !== 64'd0) begin errors++; $display("FAIL mask_rd6: got %h expected 0", rdm); end
    checks++;
    if (rd64 !== 64'h1234) begin errors++; $display("FAIL full_rd6: got %h expected 1234", rd64); end
    do_write(5'd20, 1'b0, 64'h55);
    do_read(5'd20, 1'b0);
    checks++;
    if (rdm !== 64'd0) begin errors++; $display("FAIL mask_rd20: got %h expected 0", rdm); end
    checks++;
    if (rd64 !== 64'h55) begin errors++; $display("FAIL full_rd20: got %h expected 55", rd64); end
    do_write(5'd1, 1'b0, 64'h77);
    do_read(5'd1, 1'b0);
    checks++;
    if ({rd64, rd32, rdm} !== '0) begin
      errors++; $display("FAIL time_write_rd: got %h/%h/%h expected 0", rd64, rd32, rdm);
    end
  endtask

  task automatic test_random(input int cycles);
    for (int n = 0; n < cycles; n++) begin
      ev      = $urandom;
      inh     = $urandom & $urandom;
      clr     = $urandom & $urandom & $urandom;
      wr_en   = ($urandom_range(3) == 0);
      wr_adr  = 5'($urandom_range(31));
      wr_hi   = 1'($urandom_range(1));
      wr_data = ($urandom_range(2) == 0) ? {32'hFFFF_FFFF, 28'hFFF_FFFF, 4'($urandom_range(15))}
                                         : {32'($urandom), 32'($urandom)};
      rd_en   = 1'($urandom_range(1));
      rd_adr  = 5'($urandom_range(31));
      rd_hi   = 1'($urandom_range(1));
      tick();
      checks++;
      if (rd64 !== exp_rd[0]) begin errors++; $display("FAIL rnd_rd64 cyc %0d: got %h expected %h", n, rd64, exp_rd[0]); end
      checks++;
      if (rd32 !== exp_rd[1][31:0]) begin errors++; $display("FAIL rnd_rd32 cyc %0d: got %h expected %h", n, rd32, exp_rd[1][31:0]); end
      checks++;
      if (rdm !== exp_rd[2]) begin errors++; $display("FAIL rnd_rdm cyc %0d: got %h expected %h", n, rdm, exp_rd[2]); end
      checks++;
      if (ovf64 !== mo[0]) begin errors++; $display("FAIL rnd_ovf64 cyc %0d: got %h expected %h", n, ovf64, mo[0]); end
      checks++;
      if (ovf32 !== mo[1]) begin errors++; $display("FAIL rnd_ovf32 cyc %0d: got %h expected %h", n, ovf32, mo[1]); end
      checks++;
      if (ovfm !== mo[2][7:0]) begin errors++; $display("FAIL rnd_ovfm cyc %0d: got %h expected %h", n, ovfm, mo[2][7:0]); end
    end
    idle();
  endtask

  task automatic test_reset_midop();
    test_random(20);
    ev = '1;
    rd_en = 1'b1; rd_adr = 5'd0;
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if ({rd64, rd32, rdm, ovf64, ovf32, ovfm} !== '0) begin
      errors++; $display("FAIL midop_async: got %h/%h/%h ovf %h/%h/%h expected 0", rd64, rd32, rdm, ovf64, ovf32, ovfm);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rd64 !== 64'd0) begin errors++; $display("FAIL midop_drop_rd: got %h expected 0", rd64); end
    reset_n = 1'b1;
    model_clear();
    idle();
    ev[0] = 1'b1;
    do_read(5'd0, 1'b0);
    ev[0] = 1'b0;
    checks++;
    if (rd64 !== 64'd0) begin errors++; $display("FAIL midop_rd0: got %0d expected 0", rd64); end
    do_read(5'd0, 1'b0);
    checks++;
    if (rd64 !== 64'd1) begin errors++; $display("FAIL midop_rd1: got %0d expected 1", rd64); end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_count();
    test_inhibit();
    test_overflow();
    test_write_vs_inc();
    test_split32();
    test_mask();
    test_random(600);
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
